// File: rtl/motor_pkg.sv
// Shared types and helpers for the wheel motor drive path.
// Provides the drive FSM state type, the speed command width shared with
// the direction controller, and the duty saturation function.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } motor_state_t;

  // Width of the speed command ports of the direction controller.
  localparam int SPEED_W = 21;

  // Clamp a speed request to the PWM period (100 % duty).
  function automatic logic [31:0] sat_speed(input logic [31:0] x,
                                            input logic [31:0] period);
    return (x >= period) ? period : x;
  endfunction

endpackage

// File: rtl/deadtime_timer.sv
// Start/done down-counter that times a coast interval of DEADTIME cycles.
// Ports: clk, reset (async high), start (load and run), clear (abort),
//        done (high in the last counted cycle, combinational from state).
module deadtime_timer
  import motor_pkg::*;
#(
  parameter int DEADTIME = 5_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic done
);

  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  logic [DT_W-1:0] remain;
  logic            busy;

  // remain is loaded with DEADTIME-1 so that done is seen in the
  // DEADTIME-th cycle after start, giving exactly DEADTIME busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remain <= '0;
      busy   <= 1'b0;
    end else if (clear) begin
      remain <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      remain <= DT_W'(DEADTIME - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (remain == '0) begin
        busy <= 1'b0;
      end else begin
        remain <= remain - DT_W'(1);
      end
    end
  end

  assign done = busy && (remain == '0);

endmodule

// File: rtl/motor_pwm_driver.sv
// Per-wheel H-bridge driver: speed/direction command -> PWM enable + in1/in2.
// Ports: clk, reset (async high), enable, speed, dir_fwd in;
//        pwm, in1, in2, reversing, period_start out (all registered).
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PERIOD   = 1_000_000,
  parameter int DEADTIME = 5_000,
  parameter int SPEED_W  = motor_pkg::SPEED_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir_fwd,
  output logic               pwm,
  output logic               in1,
  output logic               in2,
  output logic               reversing,
  output logic               period_start
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int DUTY_W = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  motor_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_sat;
  logic              dir_q;
  logic              dir_pend;
  logic              rev_start;
  logic              dt_done;

  assign duty_sat = DUTY_W'(sat_speed(32'(speed), 32'(PERIOD)));

  // A reversal is only taken at the period boundary, and never when the
  // same edge also drops enable.
  assign rev_start = enable && (state == RUN) && (cnt == LAST) &&
                     (dir_fwd != dir_q);

  deadtime_timer #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk   (clk),
    .reset (reset),
    .start (rev_start),
    .clear (!enable),
    .done  (dt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      duty_q       <= '0;
      dir_q        <= 1'b0;
      dir_pend     <= 1'b0;
      pwm          <= 1'b0;
      in1          <= 1'b0;
      in2          <= 1'b0;
      reversing    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      // Outputs reflect the present state one cycle later; gating with
      // enable makes a drop of enable clear the pins on the very next edge.
      // With duty == PERIOD the compare holds for every cnt, so no wrap gap.
      pwm          <= enable && (state == RUN) && (32'(cnt) < 32'(duty_q));
      in1          <= enable && (state == RUN) && dir_q;
      in2          <= enable && (state == RUN) && !dir_q;
      reversing    <= enable && (state == DEAD);
      period_start <= enable && (state == RUN) && (cnt == '0);

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state  <= RUN;
            cnt    <= '0;
            duty_q <= duty_sat;
            dir_q  <= dir_fwd;
          end
          RUN: begin
            if (cnt == LAST) begin
              cnt    <= '0;
              duty_q <= duty_sat;
              if (dir_fwd != dir_q) begin
                state    <= DEAD;
                dir_pend <= dir_fwd;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DEAD: begin
            // Direction changes seen here are ignored; dir_pend was fixed
            // on entry.
            cnt <= '0;
            if (dt_done) begin
              state  <= RUN;
              dir_q  <= dir_pend;
              duty_q <= duty_sat;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed self-checking bench for motor_pwm_driver (PERIOD=100, DEADTIME=10).
// All sampling and input driving happens on the falling clock edge.
module tb_motor_pwm_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [20:0] speed;
  logic        dir_fwd;
  logic        pwm, in1, in2, reversing, period_start;

  int checks = 0;
  int errors = 0;

  // Statistics gathered by sample(); compared inline by each test.
  int s_hi, s_ps, s_ps_first, s_in1, s_in2, s_rev, s_both;
  int both_total = 0;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .PERIOD   (100),
    .DEADTIME (10),
    .SPEED_W  (21)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .speed        (speed),
    .dir_fwd      (dir_fwd),
    .pwm          (pwm),
    .in1          (in1),
    .in2          (in2),
    .reversing    (reversing),
    .period_start (period_start)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Observe n output cycles starting with the current one, leaving the bench
  // positioned at the cycle after the last one observed.
  task automatic sample(input int n);
    s_hi = 0; s_ps = 0; s_ps_first = -1; s_in1 = 0; s_in2 = 0;
    s_rev = 0; s_both = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm) s_hi++;
      if (period_start) begin
        s_ps++;
        if (s_ps_first < 0) s_ps_first = i;
      end
      if (in1) s_in1++;
      if (in2) s_in2++;
      if (reversing) s_rev++;
      if (in1 && in2) begin
        s_both++;
        both_total++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    reset = 1'b1; enable = 1'b0; speed = '0; dir_fwd = 1'b1;
    tick(); tick();
    outs = {pwm, in1, in2, reversing, period_start};
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b expected=00000", outs);
    end
    reset = 1'b0;
    // Enable now: output cycle 0 appears after two falling edges.
    speed = 21'd50; enable = 1'b1;
    tick(); tick();
    sample(37);
    checks++;
    if (pwm !== 1'b1 || in1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_drive: pwm=%b in1=%b expected pwm=1 in1=1", pwm, in1);
    end
    reset = 1'b1; enable = 1'b0;
    #1;
    outs = {pwm, in1, in2, reversing, period_start};
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: outputs=%b expected=00000", outs);
    end
    tick();
    reset = 1'b0;
    sample(20);
    checks++;
    if (s_hi + s_ps + s_in1 + s_in2 + s_rev !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: active_count=%0d expected=0",
               s_hi + s_ps + s_in1 + s_in2 + s_rev);
    end
  endtask

  task automatic test_steady();
    speed = 21'd25; dir_fwd = 1'b1; enable = 1'b1;
    tick();
    checks++;
    if (pwm !== 1'b0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL enable_latency: pwm=%b ps=%b expected 0 0 one cycle after enable",
               pwm, period_start);
    end
    tick();
    for (int p = 0; p < 2; p++) begin
      sample(100);
      checks++;
      if (s_hi !== 25 || s_ps !== 1 || s_ps_first !== 0 || s_in1 !== 100 || s_in2 !== 0) begin
        errors++;
        $display("FAIL steady_period%0d: hi=%0d ps=%0d first=%0d in1=%0d in2=%0d expected 25 1 0 100 0",
                 p, s_hi, s_ps, s_ps_first, s_in1, s_in2);
      end
    end
  endtask

  task automatic test_mid_update();
    int hi_total;
    sample(10);
    hi_total = s_hi;
    speed = 21'd60;
    sample(90);
    hi_total += s_hi;
    checks++;
    if (hi_total !== 25) begin
      errors++;
      $display("FAIL update_current_period: hi=%0d expected=25", hi_total);
    end
    sample(100);
    checks++;
    if (s_hi !== 60 || s_ps_first !== 0) begin
      errors++;
      $display("FAIL update_next_period: hi=%0d first_ps=%0d expected 60 0", s_hi, s_ps_first);
    end
  endtask

  task automatic test_saturation();
    speed = 21'd150;
    sample(100);
    checks++;
    if (s_hi !== 60) begin
      errors++;
      $display("FAIL sat_old_period: hi=%0d expected=60", s_hi);
    end
    sample(300);
    checks++;
    if (s_hi !== 300 || s_ps !== 3) begin
      errors++;
      $display("FAIL saturation: hi=%0d ps=%0d expected 300 3", s_hi, s_ps);
    end
    speed = 21'd0;
    sample(100);
    checks++;
    if (s_hi !== 100) begin
      errors++;
      $display("FAIL sat_before_zero: hi=%0d expected=100", s_hi);
    end
    sample(200);
    checks++;
    if (s_hi !== 0 || s_ps !== 2) begin
      errors++;
      $display("FAIL zero_speed: hi=%0d ps=%0d expected 0 2", s_hi, s_ps);
    end
  endtask

  task automatic test_reversal();
    int hi_total, in1_total, in2_total;
    speed = 21'd50;
    sample(100);
    sample(30);
    hi_total = s_hi; in1_total = s_in1; in2_total = s_in2;
    dir_fwd = 1'b0;
    sample(70);
    hi_total += s_hi; in1_total += s_in1; in2_total += s_in2;
    checks++;
    if (hi_total !== 50 || in1_total !== 100 || in2_total !== 0) begin
      errors++;
      $display("FAIL reversal_fwd_completes: hi=%0d in1=%0d in2=%0d expected 50 100 0",
               hi_total, in1_total, in2_total);
    end
    // Toggling direction inside the dead time must not change the outcome.
    dir_fwd = 1'b1;
    sample(5);
    dir_fwd = 1'b0;
    hi_total = s_hi; in1_total = s_in1 + s_in2; in2_total = s_rev;
    sample(5);
    hi_total += s_hi; in1_total += s_in1 + s_in2; in2_total += s_rev;
    checks++;
    if (hi_total !== 0 || in1_total !== 0 || in2_total !== 10 || s_ps !== 0) begin
      errors++;
      $display("FAIL deadtime: pwm_hi=%0d in_hi=%0d rev=%0d ps=%0d expected 0 0 10 0",
               hi_total, in1_total, in2_total, s_ps);
    end
    sample(100);
    checks++;
    if (s_hi !== 50 || s_in2 !== 100 || s_in1 !== 0 || s_rev !== 0 || s_ps_first !== 0) begin
      errors++;
      $display("FAIL reverse_run: hi=%0d in2=%0d in1=%0d rev=%0d first_ps=%0d expected 50 100 0 0 0",
               s_hi, s_in2, s_in1, s_rev, s_ps_first);
    end
  endtask

  task automatic test_abort();
    dir_fwd = 1'b1;
    sample(100);
    checks++;
    if (s_hi !== 50 || s_in2 !== 100) begin
      errors++;
      $display("FAIL abort_setup: hi=%0d in2=%0d expected 50 100", s_hi, s_in2);
    end
    sample(4);
    checks++;
    if (s_rev !== 4 || reversing !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_dead: rev=%0d now=%b expected 4 1", s_rev, reversing);
    end
    enable = 1'b0;
    tick();
    checks++;
    if ({pwm, in1, in2, reversing, period_start} !== 5'b0) begin
      errors++;
      $display("FAIL abort_to_idle: outputs=%b expected=00000",
               {pwm, in1, in2, reversing, period_start});
    end
    sample(20);
    checks++;
    if (s_hi + s_ps + s_in1 + s_in2 + s_rev !== 0) begin
      errors++;
      $display("FAIL abort_stays_idle: active_count=%0d expected=0",
               s_hi + s_ps + s_in1 + s_in2 + s_rev);
    end
    dir_fwd = 1'b0; speed = 21'd50; enable = 1'b1;
    tick(); tick();
    checks++;
    if ({pwm, in1, in2, reversing, period_start} !== 5'b10101) begin
      errors++;
      $display("FAIL reenable_reverse: pwm,in1,in2,rev,ps=%b expected=10101",
               {pwm, in1, in2, reversing, period_start});
    end
    sample(100);
    checks++;
    if (s_hi !== 50 || s_in2 !== 100 || s_rev !== 0) begin
      errors++;
      $display("FAIL reenable_period: hi=%0d in2=%0d rev=%0d expected 50 100 0",
               s_hi, s_in2, s_rev);
    end
  endtask

  task automatic test_shoot_through();
    checks++;
    if (both_total !== 0) begin
      errors++;
      $display("FAIL no_shoot_through: in1&in2 cycles=%0d expected=0", both_total);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_mid_update();
    test_saturation();
    test_reversal();
    test_abort();
    test_shoot_through();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
